// File: rtl/cam_frame_tx.sv
// DVP camera frame generator: vsync/href timing with RGB565 test patterns
// (colour bars, x+y ramp, solid), one byte per clk, high byte first.
module cam_frame_tx #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_rgb,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);
  localparam int LP         = 2 * H_ACTIVE + H_BLANK;
  localparam int ACTIVE_LEN = 2 * H_ACTIVE;
  localparam int VSYNC_LEN  = VSYNC_LINES * LP;
  localparam int VBACK_LEN  = V_BACK * LP;
  localparam int VFRONT_LEN = V_FRONT * LP;
  localparam int MAX_A      = (VSYNC_LEN > VBACK_LEN) ? VSYNC_LEN : VBACK_LEN;
  localparam int MAX_LEN    = (MAX_A > VFRONT_LEN) ? MAX_A : VFRONT_LEN;
  // VSYNC spans at least one full line period, so this width also covers ACTIVE and HBLANK.
  localparam int CNT_W      = $clog2(MAX_LEN);
  localparam int Y_W        = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int BAR_W      = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  localparam logic [CNT_W-1:0] VSYNC_LAST  = CNT_W'(VSYNC_LEN - 1);
  localparam logic [CNT_W-1:0] VBACK_LAST  = CNT_W'(VBACK_LEN - 1);
  localparam logic [CNT_W-1:0] VFRONT_LAST = CNT_W'(VFRONT_LEN - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(ACTIVE_LEN - 1);
  localparam logic [CNT_W-1:0] HBLANK_LAST = CNT_W'(H_BLANK - 1);
  localparam logic [Y_W-1:0]   Y_LAST      = Y_W'(V_ACTIVE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_HBLANK, S_VFRONT
  } state_t;

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic [Y_W-1:0]   r_y, w_next_y;
  logic [1:0]       r_mode;
  logic [15:0]      r_solid;
  logic             w_frame_start, w_frame_end;
  logic             w_vsync, w_href;
  logic [7:0]       w_data;
  logic [15:0]      w_pixel;
  logic [CNT_W-2:0] w_x;

  function automatic logic [15:0] bar_rgb(input int x);
    int idx;
    idx = x / BAR_W;
    if (idx > 7) idx = 7;
    case (idx)
      0:       return 16'hFFFF;
      1:       return 16'hFFE0;
      2:       return 16'h07FF;
      3:       return 16'h07E0;
      4:       return 16'hF81F;
      5:       return 16'hF800;
      6:       return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; blocking here would create order-dependent races.
  // NOTE: every state register and counter is reset; there is no memory array here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_mode  <= '0;
      r_solid <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
      r_y     <= w_next_y;
      if (w_frame_start) begin
        r_mode  <= mode;
        r_solid <= solid_rgb;
      end
    end
  end

  // NOTE: every variable driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_next_state  = r_state;
    w_next_cnt    = r_cnt + 1'b1;
    w_next_y      = r_y;
    w_frame_start = 1'b0;
    w_frame_end   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (en) begin
          w_next_state  = S_VSYNC;
          w_frame_start = 1'b1;
        end
      end
      S_VSYNC: if (r_cnt == VSYNC_LAST) begin
        w_next_cnt   = '0;
        w_next_y     = '0;
        w_next_state = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
      end
      S_VBACK: if (r_cnt == VBACK_LAST) begin
        w_next_cnt   = '0;
        w_next_y     = '0;
        w_next_state = S_ACTIVE;
      end
      S_ACTIVE: if (r_cnt == ACTIVE_LAST) begin
        w_next_cnt   = '0;
        w_next_state = S_HBLANK;
      end
      S_HBLANK: if (r_cnt == HBLANK_LAST) begin
        w_next_cnt = '0;
        if (r_y != Y_LAST) begin
          w_next_y     = r_y + 1'b1;
          w_next_state = S_ACTIVE;
        end else if (V_FRONT > 0) begin
          w_next_state = S_VFRONT;
        end else begin
          w_frame_end   = 1'b1;
          w_frame_start = en;
          w_next_state  = en ? S_VSYNC : S_IDLE;
        end
      end
      S_VFRONT: if (r_cnt == VFRONT_LAST) begin
        w_next_cnt    = '0;
        w_frame_end   = 1'b1;
        w_frame_start = en;
        w_next_state  = en ? S_VSYNC : S_IDLE;
      end
      default: begin
        w_next_cnt   = '0;
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins line up with it.
  always_comb begin
    w_x     = w_next_cnt[CNT_W-1:1];
    w_vsync = (w_next_state == S_VSYNC);
    w_href  = (w_next_state == S_ACTIVE);
    case (r_mode)
      2'd1:    w_pixel = 16'(int'(w_x) + int'(w_next_y));
      2'd2:    w_pixel = r_solid;
      default: w_pixel = bar_rgb(int'(w_x));
    endcase
    w_data = 8'h00;
    if (w_href) w_data = w_next_cnt[0] ? w_pixel[7:0] : w_pixel[15:8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cam_vsync  <= 1'b0;
      cam_href   <= 1'b0;
      cam_data   <= 8'h00;
      frame_done <= 1'b0;
      frame_cnt  <= 8'h00;
    end else begin
      cam_vsync  <= w_vsync;
      cam_href   <= w_href;
      cam_data   <= w_data;
      frame_done <= w_frame_end;
      if (w_frame_end) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cam_frame_tx.sv
// Self-checking bench for cam_frame_tx: randomized frames compared cycle by
// cycle against a frame-position reference model.
module tb_cam_frame_tx;
  localparam int H     = 8;
  localparam int VA    = 4;
  localparam int HB    = 4;
  localparam int VS    = 1;
  localparam int VB    = 1;
  localparam int VF    = 1;
  localparam int LP    = 2 * H + HB;
  localparam int ACT0  = (VS + VB) * LP;
  localparam int FRAME = (VS + VB + VA + VF) * LP;

  localparam logic [7:0] BARS_LINE [16] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
    8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid_rgb = 16'h0;
  logic        cam_vsync, cam_href, frame_done;
  logic [7:0]  cam_data, frame_cnt;

  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_frames = 0;
  bit          done_pending = 1'b0;
  bit          saw_wrap = 1'b0;
  logic [7:0]  last_cnt = 8'h00;
  logic        g_next_en;
  logic [1:0]  g_next_mode, cur_m;
  logic [15:0] g_next_solid, cur_s;
  logic [7:0]  line_bytes [$];

  cam_frame_tx #(
    .H_ACTIVE(H), .V_ACTIVE(VA), .H_BLANK(HB),
    .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .solid_rgb(solid_rgb),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_pixel(input logic [1:0] m, input int x, input int y,
                                            input logic [15:0] s);
    int bw, idx;
    if (m == 2'd1) return 16'(x + y);
    if (m == 2'd2) return s;
    bw  = (H / 8 > 0) ? H / 8 : 1;
    idx = x / bw;
    if (idx > 7) idx = 7;
    case (idx)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Expected {vsync, href, data} at cycle i of a frame, counted from the first vsync cycle.
  function automatic logic [9:0] ref_out(input int i, input logic [1:0] m, input logic [15:0] s);
    int j, line, k;
    logic [15:0] p;
    if (i < VS * LP) return {1'b1, 1'b0, 8'h00};
    if (i < ACT0) return 10'h000;
    j    = i - ACT0;
    line = j / LP;
    k    = j % LP;
    if (line < VA && k < 2 * H) begin
      p = ref_pixel(m, k / 2, line, s);
      return {1'b0, 1'b1, (k % 2 == 1) ? p[7:0] : p[15:8]};
    end
    return 10'h000;
  endfunction

  task automatic note_done_cnt(input string tag, input bit pend);
    check({tag, "_cnt"}, frame_cnt, exp_frames % 256);
    if (pend) begin
      if (last_cnt == 8'hFF && frame_cnt == 8'h00) saw_wrap = 1'b1;
      last_cnt = frame_cnt;
    end
  endtask

  // Called at the negedge before the edge that enters VSYNC.
  task automatic run_frame(input logic [1:0] m, input logic [15:0] s, input int drop_at,
                           input int chg_at, input bit full, input string tag);
    int dones = 0;
    bit pend = done_pending;
    line_bytes.delete();
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 0) note_done_cnt(tag, pend);
      dones += int'(frame_done);
      if (full) begin
        check($sformatf("%s_c%0d", tag, i), {cam_vsync, cam_href, cam_data}, ref_out(i, m, s));
        if (cam_href) line_bytes.push_back(cam_data);
      end
      if (i == chg_at) begin
        mode      = 2'($urandom);
        solid_rgb = 16'($urandom);
      end
      if (i == drop_at) en = 1'b0;
      if (i == FRAME - 1) begin
        en        = g_next_en;
        mode      = g_next_mode;
        solid_rgb = g_next_solid;
      end
    end
    check({tag, "_done"}, dones, pend ? 1 : 0);
    done_pending = 1'b1;
    exp_frames++;
  endtask

  task automatic idle_phase(input int n, input bit start, input logic [1:0] nm,
                            input logic [15:0] ns, input string tag);
    int dones = 0;
    bit pend = done_pending;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) note_done_cnt(tag, pend);
      dones += int'(frame_done);
      check({tag, "_out"}, {cam_vsync, cam_href, cam_data}, 10'h000);
      if (start && i == n - 1) begin
        en        = 1'b1;
        mode      = nm;
        solid_rgb = ns;
      end
    end
    check({tag, "_done"}, dones, pend ? 1 : 0);
    done_pending = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vsync"}, cam_vsync, 1'b0);
    check({tag, "_href"}, cam_href, 1'b0);
    check({tag, "_data"}, cam_data, 8'h00);
    check({tag, "_done"}, frame_done, 1'b0);
    check({tag, "_cnt"}, frame_cnt, 8'h00);
  endtask

  task automatic advance();
    cur_m = g_next_mode;
    cur_s = g_next_solid;
  endtask

  initial begin
    logic [1:0]  m;
    logic [15:0] s;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    cur_m = 2'd2;
    cur_s = 16'h1234;
    idle_phase(3, 1'b1, cur_m, cur_s, "idle0");

    g_next_en = 1'b1; g_next_mode = 2'd0; g_next_solid = 16'($urandom);
    run_frame(cur_m, cur_s, -1, -1, 1'b1, "solid");
    check("solid_nbytes", line_bytes.size(), 64);
    if (line_bytes.size() >= 64) begin
      check("solid_hi", line_bytes[62], 8'h12);
      check("solid_lo", line_bytes[63], 8'h34);
    end

    advance();
    g_next_mode = 2'd1; g_next_solid = 16'($urandom);
    run_frame(cur_m, cur_s, -1, $urandom_range(0, FRAME - 2), 1'b1, "bars");
    if (line_bytes.size() >= 16)
      for (int k = 0; k < 16; k++) check($sformatf("bars_b%0d", k), line_bytes[k], BARS_LINE[k]);
    else check("bars_nbytes", line_bytes.size(), 64);

    advance();
    g_next_mode = 2'($urandom); g_next_solid = 16'($urandom);
    run_frame(cur_m, cur_s, -1, -1, 1'b1, "ramp");
    if (line_bytes.size() >= 64) begin
      check("ramp_y3x7_hi", line_bytes[3 * 16 + 14], 8'h00);
      check("ramp_y3x7_lo", line_bytes[3 * 16 + 15], 8'h0A);
    end else check("ramp_nbytes", line_bytes.size(), 64);

    for (int f = 0; f < 5; f++) begin
      advance();
      g_next_mode = 2'($urandom); g_next_solid = 16'($urandom);
      run_frame(cur_m, cur_s, -1, $urandom_range(0, FRAME - 2), 1'b1, "rand");
    end

    advance();
    g_next_en = 1'b0;
    run_frame(cur_m, cur_s, ACT0 + 5, -1, 1'b1, "endrop");
    m = 2'($urandom);
    s = 16'($urandom);
    idle_phase(10, 1'b1, m, s, "idle1");

    repeat (ACT0 + 6) @(negedge clk);
    check("pre_rst_href", cam_href, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    check_reset_outputs("held_rst");
    cur_m = 2'd1;
    cur_s = 16'($urandom);
    mode = cur_m;
    solid_rgb = cur_s;
    rst_n = 1'b1;
    exp_frames = 0;
    done_pending = 1'b0;
    g_next_en = 1'b1; g_next_mode = 2'd2; g_next_solid = 16'($urandom);
    run_frame(cur_m, cur_s, -1, -1, 1'b1, "postrst");

    for (int f = 0; f < 256; f++) begin
      advance();
      g_next_en = (f != 255);
      g_next_mode = 2'($urandom);
      g_next_solid = 16'($urandom);
      run_frame(cur_m, cur_s, -1, -1, 1'b0, "wrap");
    end
    idle_phase(4, 1'b0, 2'd0, 16'h0, "idle_end");
    check("wrap_seen", saw_wrap, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_frame_tx.md
CAM_FRAME_TX -- requirements
Module: cam_frame_tx

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter H_BLANK, default 144: clk cycles with href low after each active line.
REQ-004 Parameter VSYNC_LINES, default 3: line periods with vsync high.
REQ-005 Parameter V_BACK, default 17: blank line periods after vsync and before the first active line.
REQ-006 Parameter V_FRONT, default 10: blank line periods after the last active line.
REQ-007 clk  input  1  system clock; one DVP byte per cycle.
REQ-008 rst_n  input  1  reset, asynchronous and active-low.
REQ-009 en  input  1  level; enables frame generation.
REQ-010 mode  input  2  pattern select: 0 color bars, 1 ramp, 2 solid, 3 reserved (treated as 0).
REQ-011 solid_rgb  input  16  RGB565 value used in solid mode.
REQ-012 cam_vsync  output  1  frame sync, active-high.
REQ-013 cam_href  output  1  high while line bytes are valid.
REQ-014 cam_data  output  8  DVP byte.
REQ-015 frame_done  output  1  one-cycle pulse after the last V_FRONT line.
REQ-016 frame_cnt  output  8  completed-frame counter.

Function
REQ-017 Line period SHALL be LP = 2*H_ACTIVE + H_BLANK cycles; every vertical region is counted in whole LPs.
REQ-018 FSM states SHALL be IDLE, VSYNC, VBACK, ACTIVE, HBLANK, VFRONT.
REQ-019 IDLE -> VSYNC SHALL occur on the first clk with en=1; mode and solid_rgb SHALL be latched on that same edge and held for the whole frame.
REQ-020 VSYNC SHALL last VSYNC_LINES*LP cycles with cam_vsync=1; cam_vsync SHALL be 0 in every other state.
REQ-021 VBACK SHALL last V_BACK*LP cycles, then enter ACTIVE with line y=0.
REQ-022 ACTIVE SHALL last 2*H_ACTIVE cycles with cam_href=1, sending pixel x=0..H_ACTIVE-1, high byte (RGB565[15:8]) first, then low byte.
REQ-023 HBLANK SHALL last H_BLANK cycles with cam_href=0 and cam_data=0, then go to ACTIVE with y+1, or to VFRONT after y=V_ACTIVE-1.
REQ-024 VFRONT SHALL last V_FRONT*LP cycles; on its last cycle frame_done SHALL pulse and frame_cnt SHALL increment, wrapping 255->0.
REQ-025 After VFRONT, the FSM SHALL go to VSYNC (new latch of mode/solid_rgb) if en=1, else to IDLE.
REQ-026 Deasserting en mid-frame SHALL NOT truncate the frame; the current frame SHALL complete.
REQ-027 Color bars: x is divided into 8 bars of width H_ACTIVE/8 (the last bar absorbs the remainder), valued FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000, in order.
REQ-028 Ramp: pixel = (x + y) truncated to 16 bits.
REQ-029 Solid: pixel = latched solid_rgb.
REQ-030 cam_vsync, cam_href and cam_data SHALL be registered outputs, with no combinational path from inputs to outputs.
REQ-031 cam_data SHALL be 0 whenever cam_href=0.
REQ-032 A zero-valued V_BACK or V_FRONT SHALL skip that state; VSYNC_LINES, H_ACTIVE, V_ACTIVE and H_BLANK SHALL be at least 1.

Reset
REQ-033 On rst_n=0, at any time including mid-frame, the FSM SHALL go to IDLE immediately, and cam_vsync, cam_href, cam_data, frame_done, frame_cnt and all counters SHALL clear to 0.
REQ-034 After rst_n release with en=1, the first cam_vsync rise SHALL occur on the first clk edge after release.

Verification (H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1; LP=20)
REQ-035 Timing: en=1, mode=2, solid_rgb=1234 -> cam_vsync high for 20 cycles; href low for 20 cycles; then 4 lines of href high 16 / low 4; 20 idle cycles; frame_done pulse; frame_cnt=1.
REQ-036 Bars: mode=0 -> line bytes FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
REQ-037 Ramp: mode=1 -> line y=3, pixel x=7 gives bytes 00 0A.
REQ-038 en drop and latching: en cleared mid-ACTIVE -> frame completes and FSM returns to IDLE; mode changed mid-frame -> no effect until the next frame.
REQ-039 Reset mid-frame: rst_n pulsed low during ACTIVE -> all outputs 0 in the same cycle; with en=1, a new frame starts at VSYNC.
REQ-040 Wrap: run 256 frames -> frame_cnt goes 255 -> 0, with frame_done pulsing once per frame.
